// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      DRAIN = 3'd2,
      VALID = 3'd3,
      STEP  = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Loadable down-counter bounding the memory wait in the fetch stage.
// Instantiated by fetch_unit only when FETCH_TIMEOUT_EN is defined.
module fetch_timer #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             done_c
);

   logic [CNT_W-1:0] count;

   // Reload has priority; otherwise count down to zero and hold there.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign done_c = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads memory at the current PC, hands the word to
// the decoder over valid/ready, then pulses pc_incr once per accepted word.
// Optional build macro FETCH_TIMEOUT_EN bounds the memory wait to TIMEOUT
// cycles and adds the sticky fetch_err output.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
`ifdef FETCH_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 15
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_incr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic              busy
`ifdef FETCH_TIMEOUT_EN
   ,
   output logic              fetch_err
`endif
);

   fetch_state_t state;

   // hold_c keeps IDLE parked; expired_c aborts an unanswered memory read.
   logic hold_c;
   logic expired_c;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic waiting_c;
   logic timer_load_c;
   logic timer_done_c;

   assign waiting_c    = (state == REQ) || (state == DRAIN);
   // Timer sits preloaded outside the wait states and restarts on REQ->DRAIN.
   assign timer_load_c = !waiting_c || ((state == REQ) && flush && !mem_ack);

   fetch_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load_c),
      .en       (waiting_c),
      .load_val (CNT_W'(TIMEOUT - 1)),
      .done_c   (timer_done_c)
   );

   assign expired_c = waiting_c && timer_done_c && !mem_ack;
   assign hold_c    = fetch_err;

   // Sticky error flag: set on timeout, cleared by flush.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_err <= 1'b0;
      end else if (flush) begin
         fetch_err <= 1'b0;
      end else if (expired_c) begin
         fetch_err <= 1'b1;
      end
   end
`else
   assign expired_c = 1'b0;
   assign hold_c    = 1'b0;
`endif

   // Fetch sequencer with all outputs registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         mem_rd      <= 1'b0;
         mem_addr    <= '0;
         instr       <= '0;
         instr_valid <= 1'b0;
         pc_incr     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (run && !flush && !hold_c) begin
                  state    <= REQ;
                  mem_addr <= pc;
                  mem_rd   <= 1'b1;
                  busy     <= 1'b1;
               end
            end

            REQ: begin
               if (mem_ack) begin
                  mem_rd <= 1'b0;
                  if (flush) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     instr       <= mem_rdata;
                     instr_valid <= 1'b1;
                     state       <= VALID;
                  end
               end else if (expired_c) begin
                  mem_rd <= 1'b0;
                  state  <= IDLE;
                  busy   <= 1'b0;
               end else if (flush) begin
                  state <= DRAIN;
               end
            end

            DRAIN: begin
               if (mem_ack || expired_c) begin
                  mem_rd <= 1'b0;
                  state  <= IDLE;
                  busy   <= 1'b0;
               end
            end

            VALID: begin
               if (flush) begin
                  instr_valid <= 1'b0;
                  state       <= IDLE;
                  busy        <= 1'b0;
               end else if (instr_ready) begin
                  instr_valid <= 1'b0;
                  pc_incr     <= 1'b1;
                  state       <= STEP;
               end
            end

            STEP: begin
               pc_incr <= 1'b0;
               if (run && !flush) begin
                  state    <= REQ;
                  mem_addr <= pc + ADDR_W'(1);
                  mem_rd   <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state       <= IDLE;
               mem_rd      <= 1'b0;
               instr_valid <= 1'b0;
               pc_incr     <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule
